note_lane_scroller: RTL

//  Upstream feeder for the hit detector in the rhythm game. Accepts note rows from the

---
 rtl/note_lane_scroller.sv | 121 ++++++++++++
 1 files changed

// File: rtl/note_lane_scroller.sv
// Note grid for the rhythm game. Holds a LANES x ROWS grid, takes rows over valid/ready,
// and scrolls one row per beat tick, reporting notes that leave the marker row unhit.
module note_lane_scroller #(
    parameter int unsigned LANES    = 4,
    parameter int unsigned ROWS     = 16,
    parameter int unsigned TICK_DIV = 2500000
) (
    input  logic                   clk,
    input  logic                   resetb,
    input  logic                   start,
    input  logic                   stop,
    input  logic [LANES-1:0]       row_data,
    input  logic                   row_valid,
    output logic                   row_ready,
    input  logic [LANES-1:0]       clear_lane,
    output logic [LANES-1:0]       at_marker,
    output logic [LANES*ROWS-1:0]  grid,
    output logic                   scroll_tick,
    output logic [LANES-1:0]       missed,
    output logic                   underrun,
    output logic                   running
);

    localparam int unsigned CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned GRID_W = LANES * ROWS;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GRID_W-1:0]  grid_q, grid_d;
    logic               hold_valid_q, hold_valid_d;
    logic [LANES-1:0]   hold_data_q, hold_data_d;
    logic               scroll_tick_q, scroll_tick_d;
    logic [LANES-1:0]   missed_q, missed_d;
    logic               underrun_q, underrun_d;
    logic               tick;
    logic               accept;

    assign running     = (state_q == StRun);
    assign row_ready   = running && !hold_valid_q;
    assign accept      = row_valid && row_ready;
    // A stop on the last count wins: the run ends without a final scroll.
    assign tick        = running && !stop && (cnt_q == CNT_LAST);
    assign at_marker   = grid_q[(ROWS-1)*LANES +: LANES];
    assign grid        = grid_q;
    assign scroll_tick = scroll_tick_q;
    assign missed      = missed_q;
    assign underrun    = underrun_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        grid_d        = grid_q;
        hold_valid_d  = hold_valid_q;
        hold_data_d   = hold_data_q;
        scroll_tick_d = 1'b0;
        missed_d      = '0;
        underrun_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !stop) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
                if (tick) begin
                    grid_d        = {grid_q[GRID_W-LANES-1:0],
                                     hold_valid_q ? hold_data_q : {LANES{1'b0}}};
                    hold_valid_d  = 1'b0;
                    missed_d      = at_marker & ~clear_lane;
                    underrun_d    = !hold_valid_q;
                    scroll_tick_d = 1'b1;
                end else begin
                    grid_d[(ROWS-1)*LANES +: LANES] = at_marker & ~clear_lane;
                end
                // row_ready is only high with the hold empty, so a row taken in a tick
                // cycle waits in the hold for the next tick.
                if (accept) begin
                    hold_data_d  = row_data;
                    hold_valid_d = 1'b1;
                end
                if (stop) begin
                    state_d      = StIdle;
                    cnt_d        = '0;
                    grid_d       = '0;
                    hold_valid_d = 1'b0;
                    hold_data_d  = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            grid_q        <= '0;
            hold_valid_q  <= 1'b0;
            hold_data_q   <= '0;
            scroll_tick_q <= 1'b0;
            missed_q      <= '0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            grid_q        <= grid_d;
            hold_valid_q  <= hold_valid_d;
            hold_data_q   <= hold_data_d;
            scroll_tick_q <= scroll_tick_d;
            missed_q      <= missed_d;
            underrun_q    <= underrun_d;
        end
    end

endmodule
